shiftreg_sequencer: RTL and testbench
=====================================

// Module: shiftreg_sequencer
// PURPOSE
//  Command-driven controller for the 4-bit ShiftRegister datapath (modes LOAD/HOLD/RSH/LSH/RSH_IN/LSH_IN).
//  Accepts LOAD, TX (parallel-to-serial) and RX (serial-to-parallel) commands and drives the register's
//  mode/enable/inbit/loadval. Observes regval to emit serial data and capture received words.
//  Sits between a host/command source and one ShiftRegister instance.
// PARAMETERS
//  WIDTH  4  shift register width; must match the ShiftRegister instance
//  CNT_W  3  bit-counter width; must hold the value WIDTH (clog2(WIDTH+1))
// PORTS
//  clk            in   1      rising-edge clock, shared with ShiftRegister
//  rst_n          in   1      asynchronous, active-low reset
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      sequencer can accept; high only in IDLE
//  cmd_op         in   2      00 LOAD, 01 TX, 10 RX, 11 illegal
//  cmd_data       in   WIDTH  parallel word for LOAD/TX
//  cmd_len        in   CNT_W  bits to shift for TX/RX, 1..WIDTH; 0 or >WIDTH means WIDTH
//  ser_in         in   1      RX serial bit
//  ser_in_valid   in   1      ser_in is valid this cycle; RX stalls when low
//  ser_out        out  1      TX serial bit = sr_regval[WIDTH-1]
//  ser_out_valid  out  1      ser_out is valid (TX_SHIFT state)
//  rx_data        out  WIDTH  last received word, held until the next RX completes
//  busy           out  1      state != IDLE
//  done           out  1      one-cycle pulse in the DONE state
//  err            out  1      one-cycle pulse with done for an illegal op
//  sr_mode        out  3      to ShiftRegister.mode
//  sr_enable      out  1      to ShiftRegister.enable
//  sr_inbit       out  1      to ShiftRegister.inbit
//  sr_loadval     out  WIDTH  to ShiftRegister.loadval
//  sr_regval      in   WIDTH  from ShiftRegister.regval
// BEHAVIOUR
//  State, counter, latched op/data/len and rx_data are registered. sr_* and status outputs decode combinationally from state.
//  Reset (async, rst_n=0): state=IDLE, cnt=0, rx_data=0, done=err=0, busy=0.
//    Outputs take IDLE values immediately. ShiftRegister contents are not cleared.
//  Accept: cmd_valid & cmd_ready at a rising edge latches op/data/len. cmd_valid outside IDLE is ignored.
//  IDLE: sr_mode=001, sr_enable=0, cmd_ready=1. Accepted LOAD/TX -> LOAD; RX -> RX_SHIFT; op 11 -> DONE with err.
//  LOAD: sr_mode=000, sr_enable=1, sr_loadval=data. One cycle; the register loads at the exiting edge.
//    Next state is DONE for LOAD and TX_SHIFT for TX.
//  TX_SHIFT: sr_mode=011 (left shift, zero fill), sr_enable=1, ser_out_valid=1.
//    One bit per cycle, MSB first; cnt increments each cycle. Leave to DONE after len cycles.
//  RX_SHIFT with ser_in_valid=1: sr_mode=101, sr_inbit=ser_in, sr_enable=1, cnt++.
//  RX_SHIFT with ser_in_valid=0: sr_mode=001, sr_enable=1; the register holds.
//  RX_SHIFT: leave to DONE after len valid bits. The first bit lands in the MSB after WIDTH shifts.
//    For len<WIDTH, the upper bits are the prior contents shifted left.
//  DONE: done=1, sr_enable=0; one cycle, then IDLE.
//    On RX, rx_data <= sr_regval at the exiting edge. err=1 only for op 11.
//  Latency from the accept edge to done high: LOAD 2 cycles, TX len+2, RX len+1 + stall cycles, illegal 1.
//  Back-to-back commands: next accept at the earliest in the IDLE cycle after DONE (one idle cycle between commands).
//  sr_inbit=0 whenever not in RX_SHIFT. sr_loadval=data in all states (only sampled in LOAD).
// STRUCTURE
//  Shared header shiftreg_defs.vh:
//    - SR mode constants MODE_LOAD=000, HOLD=001, RSH=010, LSH=011, RSH_IN=100, LSH_IN=101
//    - cmd_op encodings
//    - state encodings IDLE/LOAD/TX_SHIFT/RX_SHIFT/DONE
//  Single flat module with no sub-module. The ShiftRegister is instantiated alongside it by the parent/bench.
// TESTING (bench instantiates sequencer + ShiftRegister, WIDTH=4, 10ns clk)
//  1. LOAD data=1010 -> sr_mode 000 for one cycle, done 2 cycles after accept, sr_regval=1010, err=0.
//  2. TX data=1010 len=4 -> ser_out 1,0,1,0 with ser_out_valid for 4 cycles.
//     sr_regval then 0000; done follows; cmd_ready=0 throughout.
//  3. RX len=4, ser_in 1,1,0,1 with ser_in_valid low for 2 cycles between bits 2 and 3
//     -> sr_mode=001 during the gap, rx_data=1101 after done.
//  4. TX data=1011 len=2 -> ser_out 1,0, sr_regval=1100. TX with len=0 -> 4 bits shifted.
//  5. Drop rst_n mid-TX after 2 bits -> same cycle busy=0, sr_enable=0, cmd_ready=1.
//     rx_data=0; a fresh LOAD then succeeds.
//  6. op=11 -> done=err=1 one cycle after accept, sr_enable never high.
//     cmd_valid held high during TX is not accepted until IDLE.

Source files
------------

// File: rtl/shiftreg_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer: ShiftRegister mode codes,
// command opcodes, controller states and the shift-length rule.
package shiftreg_sequencer_pkg;

  localparam logic [2:0] MODE_LOAD   = 3'b000;
  localparam logic [2:0] MODE_HOLD   = 3'b001;
  localparam logic [2:0] MODE_RSH    = 3'b010;
  localparam logic [2:0] MODE_LSH    = 3'b011;
  localparam logic [2:0] MODE_RSH_IN = 3'b100;
  localparam logic [2:0] MODE_LSH_IN = 3'b101;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_TX      = 2'b01,
    OP_RX      = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_TX_SHIFT = 3'd2,
    ST_RX_SHIFT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // A zero or oversized request means a full-width transfer.
  function automatic int unsigned effective_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/shift_register.sv
// Generic WIDTH-bit shift register datapath driven by the sequencer's mode/enable/inbit/loadval.
// Has its own reset so sequencer resets leave its contents untouched.
module ShiftRegister
  import shiftreg_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             enable,
  input  logic             inbit,
  input  logic [WIDTH-1:0] loadval,
  output logic [WIDTH-1:0] regval
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;

  always_comb begin
    reg_d = reg_q;
    if (enable) begin
      case (mode)
        MODE_LOAD:   reg_d = loadval;
        MODE_RSH:    reg_d = reg_q >> 1;
        MODE_LSH:    reg_d = reg_q << 1;
        MODE_RSH_IN: reg_d = {inbit, reg_q[WIDTH-1:1]};
        MODE_LSH_IN: reg_d = {reg_q[WIDTH-2:0], inbit};
        default:     reg_d = reg_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else        reg_q <= reg_d;
  end

  assign regval = reg_q;

endmodule

// File: rtl/shiftreg_sequencer.sv
// Command-driven controller for one ShiftRegister: LOAD, TX (parallel-to-serial, MSB first)
// and RX (serial-to-parallel) with a done/err pulse and a held received word.
module shiftreg_sequencer
  import shiftreg_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             ser_in,
  input  logic             ser_in_valid,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       sr_mode,
  output logic             sr_enable,
  output logic             sr_inbit,
  output logic [WIDTH-1:0] sr_loadval,
  input  logic [WIDTH-1:0] sr_regval
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_bit;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign last_bit = (cnt_inc == len_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    data_d    = data_q;
    rx_data_d = rx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          len_d  = CNT_W'(effective_len(32'(cmd_len), WIDTH));
          cnt_d  = '0;
          case (op_e'(cmd_op))
            OP_LOAD, OP_TX: state_d = ST_LOAD;
            OP_RX:          state_d = ST_RX_SHIFT;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD:     state_d = (op_q == OP_TX) ? ST_TX_SHIFT : ST_DONE;
      ST_TX_SHIFT: begin
        cnt_d = cnt_inc;
        if (last_bit) state_d = ST_DONE;
      end
      ST_RX_SHIFT: begin
        if (ser_in_valid) begin
          cnt_d = cnt_inc;
          if (last_bit) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // The last received bit has already landed in the register by now.
        if (op_q == OP_RX) rx_data_d = sr_regval;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      data_q    <= data_d;
      rx_data_q <= rx_data_d;
    end
  end

  always_comb begin
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;
    ser_out_valid = 1'b0;
    sr_mode       = MODE_HOLD;
    sr_enable     = 1'b0;
    sr_inbit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD: begin
        sr_mode   = MODE_LOAD;
        sr_enable = 1'b1;
      end
      ST_TX_SHIFT: begin
        sr_mode       = MODE_LSH;
        sr_enable     = 1'b1;
        ser_out_valid = 1'b1;
      end
      ST_RX_SHIFT: begin
        // A stalled serial input holds the register rather than disabling it.
        sr_enable = 1'b1;
        if (ser_in_valid) begin
          sr_mode  = MODE_LSH_IN;
          sr_inbit = ser_in;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        err  = (op_q == OP_ILLEGAL);
      end
      default: ;
    endcase
  end

  assign ser_out    = sr_regval[WIDTH-1];
  assign sr_loadval = data_q;
  assign rx_data    = rx_data_q;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Directed bench for shiftreg_sequencer + ShiftRegister: each command task builds the
// cycle-by-cycle expected outputs from a transaction-level model; a negedge process compares.
module tb_shiftreg_sequencer;
  import shiftreg_sequencer_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sr_rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic             ser_in;
  logic             ser_in_valid;
  logic             ser_out;
  logic             ser_out_valid;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       sr_mode;
  logic             sr_enable;
  logic             sr_inbit;
  logic [WIDTH-1:0] sr_loadval;
  logic [WIDTH-1:0] sr_regval;

  always #5 clk = ~clk;

  ShiftRegister #(.WIDTH(WIDTH)) u_sr (
    .clk     (clk),
    .rst_n   (sr_rst_n),
    .mode    (sr_mode),
    .enable  (sr_enable),
    .inbit   (sr_inbit),
    .loadval (sr_loadval),
    .regval  (sr_regval)
  );

  shiftreg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .cmd_len       (cmd_len),
    .ser_in        (ser_in),
    .ser_in_valid  (ser_in_valid),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .rx_data       (rx_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .sr_mode       (sr_mode),
    .sr_enable     (sr_enable),
    .sr_inbit      (sr_inbit),
    .sr_loadval    (sr_loadval),
    .sr_regval     (sr_regval)
  );

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       en;
    logic       sov;
    logic       ser_out;
    logic       inbit;
    logic [2:0] mode;
    logic       chk_mode;
    logic [3:0] regval;
    logic [3:0] rxd;
    logic [3:0] loadval;
    logic       chk_load;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the observable world: register contents, last received word, latched data.
  logic [3:0] m_reg;
  logic [3:0] m_rx;
  logic [3:0] m_data;
  logic       m_data_known;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("cmd_ready",     32'(cmd_ready),     32'(e.ready));
      check_output("busy",          32'(busy),          32'(e.busy));
      check_output("done",          32'(done),          32'(e.done));
      check_output("err",           32'(err),           32'(e.err));
      check_output("sr_enable",     32'(sr_enable),     32'(e.en));
      check_output("ser_out_valid", 32'(ser_out_valid), 32'(e.sov));
      check_output("ser_out",       32'(ser_out),       32'(e.ser_out));
      check_output("sr_inbit",      32'(sr_inbit),      32'(e.inbit));
      check_output("sr_regval",     32'(sr_regval),     32'(e.regval));
      check_output("rx_data",       32'(rx_data),       32'(e.rxd));
      if (e.chk_mode) check_output("sr_mode",    32'(sr_mode),    32'(e.mode));
      if (e.chk_load) check_output("sr_loadval", 32'(sr_loadval), 32'(e.loadval));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic cv, input logic [1:0] op, input logic [3:0] data,
                                input logic [2:0] len, input logic sin, input logic siv);
    cmd_valid    = cv;
    cmd_op       = op;
    cmd_data     = data;
    cmd_len      = len;
    ser_in       = sin;
    ser_in_valid = siv;
  endtask

  task automatic drive_idle();
    apply_stimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic ready, input logic bsy, input logic dn, input logic er,
                          input logic [2:0] mode, input logic chk_mode,
                          input logic en, input logic sov, input logic inbit);
    exp_t e;
    e.ready    = ready;
    e.busy     = bsy;
    e.done     = dn;
    e.err      = er;
    e.en       = en;
    e.sov      = sov;
    e.ser_out  = m_reg[3];
    e.inbit    = inbit;
    e.mode     = mode;
    e.chk_mode = chk_mode;
    e.regval   = m_reg;
    e.rxd      = m_rx;
    e.loadval  = m_data;
    e.chk_load = m_data_known;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, MODE_HOLD, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_done(input logic er);
    push_exp(1'b0, 1'b1, 1'b1, er, MODE_HOLD, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    drive_idle();
    push_idle();
    tick();
  endtask

  function automatic int bits_for(input logic [2:0] len);
    if (len == 3'd0 || len > 3'd4) return 4;
    return int'(len);
  endfunction

  task automatic do_load(input logic [3:0] data);
    apply_stimulus(1'b1, OP_LOAD, data, 3'd0, 1'b0, 1'b0);
    push_idle();
    tick();
    m_data = data;
    m_data_known = 1'b1;
    drive_idle();
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_reg = data;
    push_done(1'b0);
    tick();
  endtask

  // With hold set, a pending LOAD of pend stays on the command port for the whole transfer.
  task automatic do_tx(input logic [3:0] data, input logic [2:0] len, input logic hold, input logic [3:0] pend);
    int n;
    n = bits_for(len);
    apply_stimulus(1'b1, OP_TX, data, len, 1'b0, 1'b0);
    push_idle();
    tick();
    m_data = data;
    m_data_known = 1'b1;
    if (hold) apply_stimulus(1'b1, OP_LOAD, pend, 3'd1, 1'b0, 1'b0);
    else      drive_idle();
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_reg = data;
    for (int i = 0; i < n; i++) begin
      push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_LSH, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      m_reg = m_reg << 1;
    end
    push_done(1'b0);
    tick();
  endtask

  // Bit i of sins/valids is what the serial source presents on the i-th RX cycle.
  task automatic do_rx(input logic [2:0] len, input logic [15:0] sins, input logic [15:0] valids);
    int n;
    int got;
    n = bits_for(len);
    got = 0;
    apply_stimulus(1'b1, OP_RX, 4'b0000, len, 1'b0, 1'b0);
    push_idle();
    tick();
    m_data = 4'b0000;
    m_data_known = 1'b1;
    for (int i = 0; i < 16 && got < n; i++) begin
      apply_stimulus(1'b0, 2'b00, 4'b0000, 3'd0, sins[i] & valids[i], valids[i]);
      if (valids[i]) begin
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_LSH_IN, 1'b1, 1'b1, 1'b0, sins[i]);
        tick();
        m_reg = {m_reg[2:0], sins[i]};
        got++;
      end else begin
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    drive_idle();
    push_done(1'b0);
    tick();
    m_rx = m_reg;
  endtask

  task automatic do_illegal();
    apply_stimulus(1'b1, OP_ILLEGAL, 4'b1111, 3'd2, 1'b0, 1'b0);
    push_idle();
    tick();
    m_data = 4'b1111;
    m_data_known = 1'b1;
    drive_idle();
    push_done(1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    sr_rst_n     = 1'b0;
    m_reg        = 4'b0000;
    m_rx         = 4'b0000;
    m_data       = 4'b0000;
    m_data_known = 1'b0;
    drive_idle();
    repeat (3) tick();
    check_output("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    check_output("reset_busy",      32'(busy),      32'(0));
    check_output("reset_done",      32'(done),      32'(0));
    check_output("reset_sr_enable", 32'(sr_enable), 32'(0));
    check_output("reset_rx_data",   32'(rx_data),   32'(0));
    rst_n    = 1'b1;
    sr_rst_n = 1'b1;
    push_idle();
    tick();
    idle_cycle();

    $display("[TB] LOAD 1010");
    do_load(4'b1010);
    check_output("load_regval", 32'(sr_regval), 32'(4'b1010));
    idle_cycle();

    $display("[TB] TX 1010 len 4");
    do_tx(4'b1010, 3'd4, 1'b0, 4'b0000);
    check_output("tx4_regval", 32'(sr_regval), 32'(4'b0000));
    idle_cycle();

    $display("[TB] RX len 4 with a two-cycle stall");
    do_rx(3'd4, 16'b0000_0000_0010_0011, 16'b0000_0000_0011_0011);
    check_output("rx4_rx_data", 32'(rx_data), 32'(4'b1101));
    idle_cycle();

    $display("[TB] TX 1011 len 2, TX len 0, TX len 7");
    do_tx(4'b1011, 3'd2, 1'b0, 4'b0000);
    check_output("tx2_regval", 32'(sr_regval), 32'(4'b1100));
    idle_cycle();
    do_tx(4'b1001, 3'd0, 1'b0, 4'b0000);
    check_output("tx0_regval", 32'(sr_regval), 32'(4'b0000));
    do_tx(4'b0111, 3'd7, 1'b0, 4'b0000);
    idle_cycle();

    $display("[TB] RX len 2 keeps prior contents in upper bits");
    do_load(4'b1001);
    do_rx(3'd2, 16'b0000_0000_0000_0001, 16'b0000_0000_0000_0011);
    check_output("rx2_rx_data", 32'(rx_data), 32'(4'b0110));
    idle_cycle();

    $display("[TB] reset during TX after two bits");
    apply_stimulus(1'b1, OP_TX, 4'b0110, 3'd4, 1'b0, 1'b0);
    push_idle();
    tick();
    m_data = 4'b0110;
    drive_idle();
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_reg = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b1, 1'b0, 1'b0, MODE_LSH, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      m_reg = m_reg << 1;
    end
    rst_n = 1'b0;
    m_rx = 4'b0000;
    m_data_known = 1'b0;
    push_idle();
    #1;
    check_output("midtx_reset_busy",      32'(busy),      32'(0));
    check_output("midtx_reset_cmd_ready", 32'(cmd_ready), 32'(1));
    check_output("midtx_reset_sr_enable", 32'(sr_enable), 32'(0));
    check_output("midtx_reset_regval",    32'(sr_regval), 32'(4'b1000));
    tick();
    rst_n = 1'b1;
    push_idle();
    tick();
    do_load(4'b0011);
    check_output("post_reset_load_regval", 32'(sr_regval), 32'(4'b0011));
    idle_cycle();

    $display("[TB] illegal op");
    do_illegal();
    idle_cycle();

    $display("[TB] cmd_valid held through TX, then back-to-back LOAD");
    do_tx(4'b1100, 3'd3, 1'b1, 4'b0101);
    do_load(4'b0101);
    check_output("held_load_regval", 32'(sr_regval), 32'(4'b0101));
    idle_cycle();
    idle_cycle();

    @(negedge clk);
    #1;
    check_output("expectations_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
